// File: rtl/huff_enc_scheduler.sv
// Round-robin scheduler sharing one huff_encoder among N_REQ requesters.
// Streams a NSYM-symbol job into the encoder, captures its output words and returns them.
module huff_enc_scheduler #(
    parameter int N_REQ   = 4,
    parameter int NSYM    = 3,
    parameter int TIMEOUT = 64,
    parameter int IDW     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*NSYM*8-1:0]   req_char,
    input  logic [N_REQ*NSYM*3-1:0]   req_freq,
    output logic [N_REQ-1:0]          req_ready,
    output logic [11:0]               enc_io_in,
    input  logic [11:0]               enc_io_out,
    output logic                      enc_reset,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [NSYM*5-1:0]         rsp_char,
    output logic [NSYM*3-1:0]         rsp_mask,
    output logic [NSYM*3-1:0]         rsp_code,
    output logic                      rsp_err
);

    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam int SW  = $clog2(2*NSYM) + 1;

    typedef enum logic [2:0] {IDLE, FEED, WAIT, CAPTURE, RESP, FLUSH} state_t;

    state_t             state;
    logic [IDW-1:0]     rr_ptr;
    logic [WDW-1:0]     wdog;
    logic [SW-1:0]      idx;
    logic               hold;
    logic               flush_cnt;
    logic [NSYM*8-1:0]  job_char;
    logic [NSYM*3-1:0]  job_freq;

    logic               grant_any;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     rr_next;
    logic [IDW:0]       cand;

    // First requesting index at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(N_REQ))
                cand = cand - (IDW+1)'(N_REQ);
            if (!grant_any && req_valid[cand[IDW-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = cand[IDW-1:0];
            end
        end
        rr_next = (grant_id == IDW'(N_REQ-1)) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            wdog      <= '0;
            idx       <= '0;
            hold      <= 1'b0;
            flush_cnt <= 1'b0;
            job_char  <= '0;
            job_freq  <= '0;
            req_ready <= '0;
            enc_io_in <= '0;
            enc_reset <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_char  <= '0;
            rsp_mask  <= '0;
            rsp_code  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= '0;
            case (state)
                IDLE: begin
                    enc_io_in <= '0;
                    if (hold) begin
                        hold <= 1'b0;
                    end else if (grant_any) begin
                        req_ready[grant_id] <= 1'b1;
                        rsp_id    <= grant_id;
                        rr_ptr    <= rr_next;
                        job_char  <= req_char[grant_id*NSYM*8 +: NSYM*8];
                        job_freq  <= req_freq[grant_id*NSYM*3 +: NSYM*3];
                        // Symbol 0 is driven straight from the inputs so FEED spans exactly NSYM cycles.
                        enc_io_in <= {1'b1, req_freq[grant_id*NSYM*3 +: 3], req_char[grant_id*NSYM*8 +: 8]};
                        idx       <= SW'(1);
                        state     <= FEED;
                    end
                end
                FEED: begin
                    if (idx == SW'(NSYM)) begin
                        enc_io_in <= '0;
                        wdog      <= '0;
                        state     <= WAIT;
                    end else begin
                        enc_io_in <= {1'b1, job_freq[idx*3 +: 3], job_char[idx*8 +: 8]};
                        idx       <= idx + 1'b1;
                    end
                end
                WAIT: begin
                    if (enc_io_out[8]) begin
                        rsp_char[4:0] <= enc_io_out[4:0];
                        idx           <= SW'(1);
                        state         <= CAPTURE;
                    end else if (wdog == WDW'(TIMEOUT-1)) begin
                        enc_reset <= 1'b1;
                        flush_cnt <= 1'b0;
                        state     <= FLUSH;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (!enc_io_out[8]) begin
                        enc_reset <= 1'b1;
                        flush_cnt <= 1'b0;
                        state     <= FLUSH;
                    end else begin
                        if (idx[0]) begin
                            rsp_mask[(idx >> 1)*3 +: 3] <= enc_io_out[5:3];
                            rsp_code[(idx >> 1)*3 +: 3] <= enc_io_out[2:0];
                        end else begin
                            rsp_char[(idx >> 1)*5 +: 5] <= enc_io_out[4:0];
                        end
                        if (idx == SW'(2*NSYM-1)) begin
                            rsp_valid <= 1'b1;
                            // Registered grant adds one more cycle, keeping FEED >= 2 cycles behind this word.
                            hold      <= 1'b1;
                            state     <= RESP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RESP: begin
                    hold <= 1'b0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        state     <= IDLE;
                    end
                end
                FLUSH: begin
                    rsp_id   <= '0;
                    rsp_char <= '0;
                    rsp_mask <= '0;
                    rsp_code <= '0;
                    if (!flush_cnt) begin
                        flush_cnt <= 1'b1;
                    end else begin
                        enc_reset <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_huff_enc_scheduler.sv
// Bench for huff_enc_scheduler: behavioural encoder model plus directed/random jobs
// checked against a round-robin and Huffman-code reference.
module tb_huff_enc_scheduler;

    localparam int N_REQ   = 4;
    localparam int NSYM    = 3;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*NSYM*8-1:0] req_char;
    logic [N_REQ*NSYM*3-1:0] req_freq;
    logic [N_REQ-1:0]        req_ready;
    logic [11:0]             enc_io_in;
    logic [11:0]             enc_io_out;
    logic                    enc_reset;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [NSYM*5-1:0]       rsp_char;
    logic [NSYM*3-1:0]       rsp_mask;
    logic [NSYM*3-1:0]       rsp_code;
    logic                    rsp_err;

    int checks = 0;
    int errors = 0;
    int ptr_model = 0;
    int enc_mode = 0;   // 0 normal, 1 never done, 2 done drops on word 4

    logic [53:0] all_outs;
    assign all_outs = {req_ready, enc_io_in, enc_reset, rsp_valid, rsp_id,
                       rsp_char, rsp_mask, rsp_code, rsp_err};

    huff_enc_scheduler #(.N_REQ(N_REQ), .NSYM(NSYM), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_char(req_char), .req_freq(req_freq), .req_ready(req_ready),
        .enc_io_in(enc_io_in), .enc_io_out(enc_io_out), .enc_reset(enc_reset),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_char(rsp_char), .rsp_mask(rsp_mask), .rsp_code(rsp_code), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Huffman codes for three symbols: most frequent (lowest index on ties) gets '0',
    // the other two get '10' and '11' in index order. Returns {mask, code}.
    function automatic logic [5:0] ref_mc(input int s, input logic [3*NSYM-1:0] fr);
        int top;
        int rank;
        top = 0;
        rank = 0;
        for (int i = 1; i < NSYM; i++)
            if (fr[i*3 +: 3] > fr[top*3 +: 3]) top = i;
        if (s == top) return {3'b001, 3'b000};
        for (int i = 0; i < s; i++)
            if (i != top) rank++;
        return {3'b011, 3'b010 + 3'(rank)};
    endfunction

    // Encoder model
    logic [11:0]         m_words[2*NSYM];
    logic [8*NSYM-1:0]   m_ch;
    logic [3*NSYM-1:0]   m_fr;
    int                  m_fcnt, m_delay, m_widx;
    bit                  m_busy;

    initial begin
        m_fcnt = 0; m_busy = 0; m_delay = 0; m_widx = 0;
        forever begin
            @(posedge clk);
            if (reset || enc_reset) begin
                m_fcnt = 0;
                m_busy = 0;
                enc_io_out <= '0;
            end else begin
                enc_io_out <= '0;
                if (m_busy) begin
                    if (m_delay > 0) begin
                        m_delay--;
                    end else begin
                        if (enc_mode == 2 && m_widx == 4) begin
                            enc_io_out <= m_words[m_widx] & 12'hEFF;
                            m_busy = 0;
                        end else begin
                            enc_io_out <= m_words[m_widx];
                        end
                        m_widx++;
                        if (m_widx == 2*NSYM) m_busy = 0;
                    end
                end
                if (enc_io_in[11]) begin
                    m_ch[m_fcnt*8 +: 8] = enc_io_in[7:0];
                    m_fr[m_fcnt*3 +: 3] = enc_io_in[10:8];
                    m_fcnt++;
                    if (m_fcnt == NSYM) begin
                        m_fcnt = 0;
                        if (enc_mode != 1) begin
                            for (int s = 0; s < NSYM; s++) begin
                                m_words[2*s]   = {3'b000, 1'b1, m_ch[s*8+5 +: 3], m_ch[s*8 +: 5]};
                                m_words[2*s+1] = {3'b000, 1'b1, 2'b00, ref_mc(s, m_fr)};
                            end
                            m_busy  = 1;
                            m_widx  = 0;
                            m_delay = $urandom_range(0, 6);
                        end
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic fill_random;
        for (int r = 0; r < N_REQ; r++)
            for (int s = 0; s < NSYM; s++) begin
                req_char[(r*NSYM+s)*8 +: 8] = 8'($urandom);
                req_freq[(r*NSYM+s)*3 +: 3] = 3'($urandom);
            end
    endtask

    task automatic run_job(input logic [N_REQ-1:0] valid, input int mode, input int stall,
                           input bit drop_winner);
        int w, lat, rst_cnt, rst_first, rst_last, rsp_t;
        bit got, quiet;
        logic [8*NSYM-1:0] ch;
        logic [3*NSYM-1:0] fr;
        logic [5*NSYM-1:0] e_char;
        logic [3*NSYM-1:0] e_mask, e_code;
        logic [IDW-1:0]    e_id;
        logic              e_err;
        w = -1;
        for (int i = 0; i < N_REQ; i++)
            if (w < 0 && valid[(ptr_model+i) % N_REQ]) w = (ptr_model+i) % N_REQ;
        ch = req_char[w*NSYM*8 +: NSYM*8];
        fr = req_freq[w*NSYM*3 +: NSYM*3];
        enc_mode = mode;
        req_valid = valid;
        lat = 0;
        got = 0;
        while (!got && lat < 50) begin
            tick;
            lat++;
            if (req_ready != '0) got = 1;
        end
        chk("grant_onehot", 64'(req_ready), 64'(1 << w));
        chk("grant_latency", 64'(lat), 64'd1);
        if (!got) return;
        ptr_model = (w + 1) % N_REQ;
        if (drop_winner) req_valid[w] = 1'b0;
        req_char[w*NSYM*8 +: NSYM*8] = ~ch;
        req_freq[w*NSYM*3 +: NSYM*3] = ~fr;
        for (int s = 0; s < NSYM; s++) begin
            if (s > 0) tick;
            chk($sformatf("feed%0d", s), 64'(enc_io_in), 64'({1'b1, fr[s*3 +: 3], ch[s*8 +: 8]}));
            if (s == 1) chk("ready_pulse", 64'(req_ready), 64'd0);
        end
        tick;
        chk("feed_end", 64'(enc_io_in), 64'd0);

        rst_cnt = 0; rst_first = -1; rst_last = -1; rsp_t = -1; quiet = 1;
        for (int t = 1; t <= 300 && rsp_t < 0; t++) begin
            tick;
            if (enc_io_in[11] || req_ready != '0) quiet = 0;
            if (enc_reset) begin
                rst_cnt++;
                if (rst_first < 0) rst_first = t;
                rst_last = t;
            end
            if (rsp_valid) rsp_t = t;
        end
        chk("rsp_arrived", 64'(rsp_t > 0), 64'd1);
        chk("quiet_wait", 64'(quiet), 64'd1);
        if (mode == 0) begin
            chk("no_enc_reset", 64'(rst_cnt), 64'd0);
        end else begin
            chk("enc_reset_len", 64'(rst_cnt), 64'd2);
            chk("rsp_after_reset", 64'(rsp_t), 64'(rst_last + 1));
        end
        if (mode == 1) chk("wdog_cycles", 64'(rst_first), 64'(TIMEOUT));

        e_err = (mode != 0);
        e_id = e_err ? '0 : IDW'(w);
        e_char = '0; e_mask = '0; e_code = '0;
        if (!e_err)
            for (int s = 0; s < NSYM; s++) begin
                e_char[s*5 +: 5] = ch[s*8 +: 5];
                {e_mask[s*3 +: 3], e_code[s*3 +: 3]} = ref_mc(s, fr);
            end
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
        chk("rsp_id", 64'(rsp_id), 64'(e_id));
        chk("rsp_char", 64'(rsp_char), 64'(e_char));
        chk("rsp_mask", 64'(rsp_mask), 64'(e_mask));
        chk("rsp_code", 64'(rsp_code), 64'(e_code));
        for (int i = 0; i < stall; i++) begin
            tick;
            chk("stall_hold",
                64'({rsp_valid, rsp_err, rsp_id, rsp_char, rsp_mask, rsp_code, req_ready, enc_io_in[11]}),
                64'({1'b1, e_err, e_id, e_char, e_mask, e_code, {N_REQ{1'b0}}, 1'b0}));
        end
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("rsp_release", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b0; req_valid = '0; req_char = '0; req_freq = '0;
        repeat (3) tick;
        chk("reset_outputs", 64'(all_outs), 64'd0);
        reset = 1'b0;

        // Requester 2: 'a','b','c' with frequencies 1,2,4
        req_char[(2*NSYM)*8 +: NSYM*8] = {8'h63, 8'h62, 8'h61};
        req_freq[(2*NSYM)*3 +: NSYM*3] = {3'd4, 3'd2, 3'd1};
        run_job(4'b0100, 0, 0, 1'b1);

        // All requesters valid continuously, 20-cycle consumer stall on the third job
        reset = 1'b1; tick; reset = 1'b0; ptr_model = 0;
        fill_random;
        for (int j = 0; j < 5; j++) run_job(4'b1111, 0, (j == 2) ? 20 : 0, 1'b0);
        req_valid = '0;

        // Watchdog abort, then a normal job
        fill_random;
        run_job(4'b0010, 1, 3, 1'b1);
        run_job(4'b0010, 0, 0, 1'b1);

        // done drops mid-capture
        fill_random;
        run_job(4'b1000, 2, 0, 1'b1);
        fill_random;
        run_job(4'b1001, 0, 1, 1'b1);

        // Reset during the second FEED cycle, then retry
        req_valid = '0;
        reset = 1'b1; tick; reset = 1'b0; ptr_model = 0;
        fill_random;
        req_valid = 4'b0010;
        tick;
        chk("mid_grant", 64'(req_ready), 64'b0010);
        req_valid = '0;
        tick;
        chk("mid_feed_active", 64'(enc_io_in[11]), 64'd1);
        reset = 1'b1;
        tick;
        chk("mid_reset_outputs", 64'(all_outs), 64'd0);
        reset = 1'b0;
        run_job(4'b0010, 0, 0, 1'b1);

        // Random jobs
        for (int j = 0; j < 10; j++) begin
            fill_random;
            run_job(N_REQ'($urandom_range(1, 15)), 0, $urandom_range(0, 3), 1'b1);
            req_valid = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/huff_enc_scheduler.md
Name: huff_enc_scheduler

Overview:
- Shares one huff_encoder instance among N_REQ requesters.
- Each requester submits a complete 3-symbol job: characters plus frequencies.
- The block arbitrates round-robin, streams the job into the encoder's 12-bit io_in port, and captures the encoder's output word stream.
- It returns per-symbol character/mask/code triples to the winning requester, with a watchdog that resets the encoder on a hang.

Parameters:
N_REQ, 4, number of requesters (2..8)
NSYM, 3, symbols per job; must equal encoder MAX_CHAR_COUNT
TIMEOUT, 64, max cycles waiting for encoder done before abort
IDW, 2, width of requester id = clog2(N_REQ)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  job request per requester
req_char  in  N_REQ*NSYM*8  packed characters; requester i, symbol s at [(i*NSYM+s)*8 +: 8]
req_freq  in  N_REQ*NSYM*3  packed frequencies, same indexing with width 3
req_ready  out  N_REQ  one-hot, 1-cycle pulse: job accepted
enc_io_in  out  12  to encoder io_in: [11] data_en, [10:8] freq, [7:0] char
enc_io_out  in  12  from encoder io_out: [8] done; char word [4:0]; code word [5:3] mask, [2:0] value
enc_reset  out  1  synchronous reset to encoder (OR'd with system reset externally)
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  IDW  requester index of result
rsp_char  out  NSYM*5  captured characters, symbol s at [s*5 +: 5]
rsp_mask  out  NSYM*3  code length masks
rsp_code  out  NSYM*3  code values
rsp_err  out  1  1 = job aborted by watchdog; other rsp fields are 0

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - All outputs 0, including enc_io_in=0 and enc_reset=0.
  - Capture registers 0, counters 0.
- States: IDLE, FEED, WAIT, CAPTURE, RESP, FLUSH.
- IDLE:
  - If any req_valid, pick the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Same cycle: pulse req_ready[winner], latch that requester's chars/freqs and id, set rr_ptr=winner+1 (wrapping), go to FEED.
  - No request -> stay in IDLE with enc_io_in=0.
- FEED:
  - For NSYM consecutive cycles, drive enc_io_in={1'b1, freq[s], char[s]} for s=0..NSYM-1.
  - Then drive 0 and go to WAIT.
  - data_en is never high outside FEED.
- WAIT:
  - Increment wdog each cycle.
  - On enc_io_out[8]=1, go to CAPTURE and treat that word as word 0 (a char word).
  - If wdog reaches TIMEOUT-1 without done, go to FLUSH.
- CAPTURE:
  - Take 2*NSYM words, one per cycle, starting with the WAIT-exit word.
  - Even words are char words: store [4:0] to rsp_char[k]. Odd words are code words: store [5:3] to mask[k] and [2:0] to code[k]. k increments after each odd word.
  - A word with [8]=0 during CAPTURE aborts to FLUSH.
  - After word 2*NSYM-1, go to RESP.
- RESP:
  - Assert rsp_valid, with fields stable, until rsp_ready=1.
  - rsp_valid & rsp_ready -> clear rsp_valid and go to IDLE.
  - No new grant occurs while in RESP (single outstanding job).
- FLUSH:
  - Assert enc_reset for 2 cycles, clear capture registers, present rsp_valid=1 with rsp_err=1, then behave as RESP.
- wdog counts from 0, is cleared on entry to WAIT, and is width clog2(TIMEOUT)+1.
- Encoder restart: after SEND_OUTPUT the encoder returns to data collection on its own. The scheduler must not re-enter FEED sooner than 2 cycles after the last CAPTURE word; a holdoff counter in RESP/IDLE enforces this.
- A req_valid drop before grant is legal and silently withdraws the request. Inputs are sampled only in the grant cycle.
- Reset mid-job returns to IDLE with all outputs 0 and discards the in-flight job. The encoder must be reset by the same system reset.

Test Plan:
- Single job, requester 2, chars 'a','b','c' (0x61,0x62,0x63), freqs 1,2,4:
  - req_ready[2] pulses one cycle after req_valid[2].
  - enc_io_in shows 0x961, 0xA62, 0xC63 on 3 consecutive cycles.
  - rsp_id=2, rsp_char=1,2,3, with masks/codes matching the encoder model.
- All 4 requesters valid continuously: grants in order 0,1,2,3,0 across 5 jobs; never two req_ready bits set in one cycle.
- Encoder model never raises done: after TIMEOUT cycles in WAIT, enc_reset is high 2 cycles, then rsp_valid=1, rsp_err=1, rsp_char=0; the next job completes normally.
- rsp_ready held low 20 cycles: rsp fields stable, no grant and enc_io_in[11]=0 throughout; grant occurs 1 cycle after the handshake.
- done drops after word 3 of CAPTURE -> FLUSH path, rsp_err=1.
- reset asserted during FEED cycle 2: next cycle all outputs 0, state IDLE, and the requester's retried job completes with correct results.
